// File: rtl/fifo_serializer_pkg.sv
// Shared types for the FIFO drain serializer: FSM state encoding.
package fifo_ser_pkg;
   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      IDLE    = 2'd0,
      POP     = 2'd1,
      CAPTURE = 2'd2,
      SHIFT   = 2'd3
   } state_t;
endpackage

// File: rtl/fifo_serializer_if.sv
// FIFO read side plus valid/ready serial stream, seen from the serializer (master).
interface fifo_serializer_if #(
   parameter int DATA_WIDTH = 8
) ();
   logic                  fifo_empty;
   logic                  fifo_pop;
   logic [DATA_WIDTH-1:0] fifo_data;
   logic                  ser_data;
   logic                  ser_valid;
   logic                  ser_ready;
   logic                  ser_first;
   logic                  ser_last;

   modport master (
      input  fifo_empty, fifo_data, ser_ready,
      output fifo_pop, ser_data, ser_valid, ser_first, ser_last
   );

   modport slave (
      output fifo_empty, fifo_data, ser_ready,
      input  fifo_pop, ser_data, ser_valid, ser_first, ser_last
   );
endinterface

// File: rtl/fifo_serializer.sv
// Pops one word at a time from a synchronous FIFO and streams it out bit-serially
// with first/last framing on a valid/ready handshake.
module fifo_serializer
   import fifo_ser_pkg::*;
#(
   parameter int  DATA_WIDTH = 8,
   parameter bit  MSB_FIRST  = 1'b0,
   localparam int CNT_WIDTH  = $clog2(DATA_WIDTH)
) (
   input  logic                  clk,
   input  logic                  reset,
   fifo_serializer_if.master     bus,
   output logic                  busy
);
   localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(DATA_WIDTH - 1);

   state_t                  state_reg, state_next;
   logic [DATA_WIDTH-1:0]   shreg_reg, shreg_next;
   logic [CNT_WIDTH-1:0]    cnt_reg, cnt_next;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= IDLE;
         shreg_reg <= '0;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         shreg_reg <= shreg_next;
         cnt_reg   <= cnt_next;
      end
   end

   // The counter saturates at LAST_CNT on the final beat; CAPTURE clears it for the next word.
   always_comb begin
      state_next = state_reg;
      shreg_next = shreg_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         IDLE: begin
            if (!bus.fifo_empty) state_next = POP;
         end
         POP: begin
            state_next = CAPTURE;
         end
         CAPTURE: begin
            shreg_next = bus.fifo_data;
            cnt_next   = '0;
            state_next = SHIFT;
         end
         SHIFT: begin
            if (bus.ser_ready) begin
               if (MSB_FIRST) shreg_next = {shreg_reg[DATA_WIDTH-2:0], 1'b0};
               else           shreg_next = {1'b0, shreg_reg[DATA_WIDTH-1:1]};
               if (cnt_reg == LAST_CNT) state_next = IDLE;
               else                     cnt_next   = cnt_reg + 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Every output decodes registered state only, so nothing depends on ser_ready combinationally.
   always_comb begin
      bus.fifo_pop  = 1'b0;
      bus.ser_valid = 1'b0;
      bus.ser_first = 1'b0;
      bus.ser_last  = 1'b0;
      bus.ser_data  = MSB_FIRST ? shreg_reg[DATA_WIDTH-1] : shreg_reg[0];
      busy          = (state_reg != IDLE);
      if (state_reg == POP) bus.fifo_pop = 1'b1;
      if (state_reg == SHIFT) begin
         bus.ser_valid = 1'b1;
         bus.ser_first = (cnt_reg == '0);
         bus.ser_last  = (cnt_reg == LAST_CNT);
      end
   end
endmodule

// File: tb/tb_fifo_serializer.sv
// Bench for fifo_serializer: LSB-first and MSB-first instances fed by FIFO models,
// with a beat scoreboard checked on the falling edge.
module tb_fifo_serializer;
   typedef struct packed {
      logic d;
      logic f;
      logic l;
   } beat_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] busy_w;
   int         n_cmp = 0;
   int         n_err = 0;
   int         cyc = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_cmp++;
      if (obs !== exp_v) begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar gi = 0; gi < 2; gi++) begin : g
      fifo_serializer_if #(.DATA_WIDTH(8)) ifc ();

      fifo_serializer #(
         .DATA_WIDTH (8),
         .MSB_FIRST  (1'(gi))
      ) dut (
         .clk   (clk),
         .reset (reset),
         .bus   (ifc.master),
         .busy  (busy_w[gi])
      );

      // FIFO model: registered empty flag, read data valid the cycle after a pop.
      logic [7:0] mem_q[$];
      logic       empty_r = 1'b1;
      logic [7:0] data_r  = 8'h00;
      assign ifc.fifo_empty = empty_r;
      assign ifc.fifo_data  = data_r;

      always @(posedge clk) begin
         if (ifc.fifo_pop && mem_q.size() > 0) data_r <= mem_q.pop_front();
         empty_r <= (mem_q.size() == 0);
      end

      beat_t exp_q[$];
      int    pop_cyc[$];
      int    acc_cnt  = 0;
      int    pop_at   = 0;
      bit    last_acc = 1'b0;
      bit    lat_done = 1'b0;
      beat_t e;

      always @(negedge clk) begin
         if (reset) begin
            check("pop_in_reset", ifc.fifo_pop, 1'b0);
            acc_cnt  = 0;
            last_acc = 1'b0;
            lat_done = 1'b0;
         end else begin
            if (ifc.fifo_pop) begin
               check("pop_while_empty", ifc.fifo_empty, 1'b0);
               pop_cyc.push_back(cyc);
               pop_at = cyc;
            end
            if (last_acc) begin
               check("busy_after_last", busy_w[gi], 1'b0);
               last_acc = 1'b0;
            end
            if (ifc.ser_valid) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_valid", ifc.ser_valid, 1'b0);
               end else begin
                  e = exp_q[0];
                  if (!lat_done) begin
                     check("pop_to_valid_latency", cyc - pop_at, 2);
                     lat_done = 1'b1;
                  end
                  check("ser_data", ifc.ser_data, e.d);
                  check("ser_first", ifc.ser_first, e.f);
                  check("ser_last", ifc.ser_last, e.l);
                  if (ifc.ser_ready) begin
                     void'(exp_q.pop_front());
                     acc_cnt++;
                     if (e.l) begin
                        acc_cnt  = 0;
                        last_acc = 1'b1;
                        lat_done = 1'b0;
                     end
                  end
               end
            end
         end
      end
   end

   task automatic push_word(input int lane, input logic [7:0] w);
      beat_t b;
      for (int i = 0; i < 8; i++) begin
         b.d = (lane == 1) ? w[7-i] : w[i];
         b.f = (i == 0);
         b.l = (i == 7);
         if (lane == 0) g[0].exp_q.push_back(b);
         else           g[1].exp_q.push_back(b);
      end
      if (lane == 0) g[0].mem_q.push_back(w);
      else           g[1].mem_q.push_back(w);
   endtask

   function automatic int pending(input int lane);
      if (lane == 0) return g[0].exp_q.size() + g[0].mem_q.size() + int'(busy_w[0]);
      return g[1].exp_q.size() + g[1].mem_q.size() + int'(busy_w[1]);
   endfunction

   task automatic wait_drain(input int lane, input int budget);
      for (int i = 0; i < budget; i++) begin
         @(posedge clk);
         #1;
         if (pending(lane) == 0) break;
      end
      check("drained", pending(lane), 0);
   endtask

   task automatic wait_acc(input int lane, input int n, input int budget);
      int got;
      got = -1;
      for (int i = 0; i < budget; i++) begin
         @(posedge clk);
         #1;
         got = (lane == 0) ? g[0].acc_cnt : g[1].acc_cnt;
         if (got == n) break;
      end
      check("beats_reached", got, n);
   endtask

   task automatic check_idle_outputs(input int lane);
      if (lane == 0) begin
         check("rst_busy", busy_w[0], 1'b0);
         check("rst_pop", g[0].ifc.fifo_pop, 1'b0);
         check("rst_valid", g[0].ifc.ser_valid, 1'b0);
         check("rst_data", g[0].ifc.ser_data, 1'b0);
         check("rst_first", g[0].ifc.ser_first, 1'b0);
         check("rst_last", g[0].ifc.ser_last, 1'b0);
      end else begin
         check("rst_busy", busy_w[1], 1'b0);
         check("rst_pop", g[1].ifc.fifo_pop, 1'b0);
         check("rst_valid", g[1].ifc.ser_valid, 1'b0);
         check("rst_data", g[1].ifc.ser_data, 1'b0);
         check("rst_first", g[1].ifc.ser_first, 1'b0);
         check("rst_last", g[1].ifc.ser_last, 1'b0);
      end
   endtask

   initial begin
      g[0].ifc.ser_ready = 1'b1;
      g[1].ifc.ser_ready = 1'b1;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_idle_outputs(0);
      check_idle_outputs(1);
      reset = 1'b0;
      $display("step: reset state checked");

      // Single word, LSB-first, free-flowing consumer.
      g[0].pop_cyc.delete();
      push_word(0, 8'hA5);
      wait_drain(0, 40);
      check("a5_pop_count", g[0].pop_cyc.size(), 1);
      $display("step: word 0xA5 lsb-first");

      // Backpressure: stall three cycles while beat 2 is presented.
      push_word(0, 8'h3C);
      wait_acc(0, 2, 40);
      g[0].ifc.ser_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      g[0].ifc.ser_ready = 1'b1;
      wait_drain(0, 40);
      $display("step: word 0x3C with 3-cycle stall at beat 2");

      // Back-to-back words: pops spaced DATA_WIDTH+3 cycles apart.
      g[0].pop_cyc.delete();
      push_word(0, 8'h01);
      push_word(0, 8'h80);
      wait_drain(0, 60);
      check("b2b_pop_count", g[0].pop_cyc.size(), 2);
      if (g[0].pop_cyc.size() == 2) begin
         check("b2b_pop_spacing", g[0].pop_cyc[1] - g[0].pop_cyc[0], 11);
      end
      $display("step: back-to-back words 0x01, 0x80");

      // MSB-first instance.
      g[1].pop_cyc.delete();
      push_word(1, 8'hA5);
      wait_drain(1, 40);
      check("msb_pop_count", g[1].pop_cyc.size(), 1);
      $display("step: word 0xA5 msb-first");

      // Reset at beat 4 of 0xFF; the queued 0x0F must follow from beat 0.
      g[0].pop_cyc.delete();
      push_word(0, 8'hFF);
      push_word(0, 8'h0F);
      wait_acc(0, 4, 40);
      reset = 1'b1;
      #1;
      check_idle_outputs(0);
      repeat (2) @(posedge clk);
      #1;
      while (g[0].exp_q.size() > 0 && !g[0].exp_q[0].f) void'(g[0].exp_q.pop_front());
      reset = 1'b0;
      wait_drain(0, 40);
      check("midreset_pop_count", g[0].pop_cyc.size(), 2);
      $display("step: reset mid-shift, next word 0x0F");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/fifo_serializer.md
# fifo_serializer

Downstream drain stage for the synchronous `fifo` block. It pops one DATA_WIDTH-bit word at a time from the FIFO and emits the word one bit per accepted beat on a valid/ready serial stream. Each word is framed with first/last markers. It owns the FIFO's `pop` input and reads its `empty` and `data_out`.

## Interface
Parameters:
- DATA_WIDTH, 8, word width; must match the FIFO's DATA_WIDTH; legal values are ≥ 2.
- MSB_FIRST, 0, 0 = bit 0 shifted out first; 1 = bit DATA_WIDTH-1 shifted out first.
- CNT_WIDTH, $clog2(DATA_WIDTH), width of the bit counter; derived, never overridden.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- fifo_empty  in  1  FIFO empty flag.
- fifo_pop  out  1  pop request to FIFO; registered.
- fifo_data  in  DATA_WIDTH  FIFO read data; valid in the cycle after fifo_pop is high.
- ser_data  out  1  current serial bit.
- ser_valid  out  1  ser_data is valid.
- ser_ready  in  1  consumer accepts the bit on a cycle where ser_valid && ser_ready.
- ser_first  out  1  high with the first bit of a word.
- ser_last  out  1  high with the last bit of a word.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, POP, CAPTURE, SHIFT.
  - IDLE: if !fifo_empty → POP; otherwise stay in IDLE.
  - POP: fifo_pop = 1 for exactly this cycle; next state is CAPTURE unconditionally.
  - CAPTURE: load fifo_data into the shift register; clear the bit counter; next state is SHIFT.
  - SHIFT: ser_valid = 1. On each accepted beat, shift one position and increment the counter. An accepted beat with counter == DATA_WIDTH-1 goes to IDLE.
- Bit output:
  - ser_data = shreg[0] when MSB_FIRST = 0; ser_data = shreg[DATA_WIDTH-1] when MSB_FIRST = 1.
  - Shift direction matches: right shift for LSB-first, left shift for MSB-first; zero-fill.
- Framing flags:
  - ser_first = SHIFT && counter == 0.
  - ser_last = SHIFT && counter == DATA_WIDTH-1.
- Stall behaviour: while ser_valid && !ser_ready, ser_data, ser_first, ser_last, the counter and the shift register all hold.
- Pop rules: the block never pops while fifo_empty is high and never issues two pops without passing through IDLE. Because of this, the FIFO's registered empty flag is always current when sampled.
- Counter arithmetic: the counter is CNT_WIDTH bits. It only counts 0..DATA_WIDTH-1 and never wraps; it is reset on CAPTURE.
- fifo_empty and fifo_data are ignored in every state except where listed above. Changes to fifo_empty during SHIFT have no effect.

## Timing
- Reset values:
  - Outputs: fifo_pop = 0, ser_valid = 0, ser_data = 0, ser_first = 0, ser_last = 0, busy = 0.
  - Internal: state = IDLE, shift register = 0, counter = 0.
- Latency: fifo_empty falling, sampled in IDLE at edge N, gives fifo_pop high in cycle N+1, capture in N+2, and the first ser_valid in N+3.
- Throughput: with ser_ready held high, DATA_WIDTH+3 cycles per word (DATA_WIDTH SHIFT cycles, 1 IDLE, 1 POP, 1 CAPTURE).
- Handshake: ser_valid does not depend combinationally on ser_ready. Once ser_valid is asserted, it stays high until the last bit is accepted.
- Reset mid-word: asserting reset in any state aborts immediately. The partially sent word is lost and is not re-fetched. ser_valid drops asynchronously.

## Structure
- Shared package `fifo_ser_pkg` holds:
  - the state enum typedef (IDLE, POP, CAPTURE, SHIFT; 2-bit encoding);
  - the localparam for the state width.
- Single module, no sub-modules. Shift register, counter and FSM are inline; each is too small to justify a separate instance.

## Test plan
- Reset: assert reset mid-simulation → all outputs 0 in the same cycle, state IDLE, no fifo_pop while reset is high.
- Single word, LSB-first: FIFO holds 8'hA5, ser_ready = 1 →
  - exactly one fifo_pop pulse;
  - ser_data sequence 1,0,1,0,0,1,0,1;
  - ser_first on beat 0 and ser_last on beat 7;
  - busy is low again 1 cycle after ser_last is accepted.
- Backpressure: word 8'h3C with ser_ready low for 3 cycles at beat 2 → ser_data/ser_first/ser_last hold; output stream is still 0,0,1,1,1,1,0,0 with no duplicated or dropped bits.
- Back-to-back words: FIFO holds 8'h01 then 8'h80, ser_ready = 1 →
  - two pops spaced DATA_WIDTH+3 cycles apart;
  - bitstream 10000000 00000001;
  - no pop after fifo_empty rises.
- MSB_FIRST = 1: word 8'hA5 → bitstream 1,0,1,0,0,1,0,1 read from bit 7 downward.
- Reset mid-shift: assert reset at beat 4 of 8'hFF, with the FIFO still holding 8'h0F →
  - ser_valid drops immediately;
  - after release, the next word sent is 8'h0F from beat 0 with ser_first = 1.
